flash_read_arbiter: RTL

//  Shares the single Avalon-MM flash read port between two requesters: the audio sample

---
 rtl/flash_arb_pkg.sv | 14 +
 rtl/arb_pick_2.sv | 28 ++
 rtl/flash_read_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port flash read arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESPOND} arb_state_t;

  localparam int unsigned NUM_PORTS  = 2;
  localparam logic [3:0]  BYTEEN_ALL = 4'b1111;

  // One-hot done vector for the port that owns the current read.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_pick_2.sv
// Combinational winner select for two requesters.
// ROUND_ROBIN_EN: alternate on contention, otherwise port 0 has fixed priority.
module arb_pick_2
  import flash_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_grant,
  output logic                 grant_valid_c,
  output logic                 grant_port_c
);

  always_comb begin
    grant_valid_c = |req;
`ifdef ROUND_ROBIN_EN
    // Contention goes to the port that did not win last time.
    if (&req) grant_port_c = ~last_grant;
    else      grant_port_c = ~req[0];
`else
    grant_port_c = ~req[0];
`endif
  end

`ifndef ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read port between the audio counter (port 0) and the loader (port 1).
// Optional ROUND_ROBIN_EN selects round-robin arbitration instead of fixed port-0 priority.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk50M,
  input  logic                 reset_n,
  input  logic [1:0]           req,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  output logic [1:0]           done,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_err,
  output logic                 flash_mem_read,
  output logic [ADDR_W-1:0]    flash_mem_address,
  output logic [3:0]           flash_mem_byteenable,
  input  logic                 flash_mem_waitrequest,
  input  logic [DATA_W-1:0]    flash_mem_readdata,
  input  logic                 flash_mem_readdatavalid
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  arb_state_t          state, state_nxt;
  logic                owner, owner_nxt;
  logic                last_grant, last_grant_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic                read_nxt;
  logic [ADDR_W-1:0]   address_nxt;
  logic [3:0]          byteen_nxt;
  logic [1:0]          done_nxt;
  logic [DATA_W-1:0]   rd_data_nxt;
  logic                rd_err_nxt;

  logic grant_valid_c;
  logic grant_port_c;

  arb_pick_2 u_pick (
    .req           (req),
    .last_grant    (last_grant),
    .grant_valid_c (grant_valid_c),
    .grant_port_c  (grant_port_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      owner                <= 1'b0;
      last_grant           <= 1'b1;
      timer                <= '0;
      flash_mem_read       <= 1'b0;
      flash_mem_address    <= '0;
      flash_mem_byteenable <= 4'b0000;
      done                 <= 2'b00;
      rd_data              <= '0;
      rd_err               <= 1'b0;
    end else begin
      state                <= state_nxt;
      owner                <= owner_nxt;
      last_grant           <= last_grant_nxt;
      timer                <= timer_nxt;
      flash_mem_read       <= read_nxt;
      flash_mem_address    <= address_nxt;
      flash_mem_byteenable <= byteen_nxt;
      done                 <= done_nxt;
      rd_data              <= rd_data_nxt;
      rd_err               <= rd_err_nxt;
    end
  end

  // Next-state and next-output logic; done is a single-cycle pulse in RESPOND.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    read_nxt       = flash_mem_read;
    address_nxt    = flash_mem_address;
    byteen_nxt     = flash_mem_byteenable;
    done_nxt       = 2'b00;
    rd_data_nxt    = rd_data;
    rd_err_nxt     = rd_err;

    case (state)
      IDLE: begin
        if (grant_valid_c) begin
          owner_nxt      = grant_port_c;
          last_grant_nxt = grant_port_c;
          address_nxt    = grant_port_c ? addr1 : addr0;
          read_nxt       = 1'b1;
          byteen_nxt     = BYTEEN_ALL;
          state_nxt      = ISSUE;
        end
      end

      ISSUE: begin
        if (!flash_mem_waitrequest) begin
          read_nxt   = 1'b0;
          byteen_nxt = 4'b0000;
          timer_nxt  = '0;
          // Data may come back in the same cycle the read is accepted.
          if (flash_mem_readdatavalid) begin
            rd_data_nxt = flash_mem_readdata;
            rd_err_nxt  = 1'b0;
            done_nxt    = port_onehot(owner);
            state_nxt   = RESPOND;
          end else begin
            state_nxt   = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          rd_data_nxt = flash_mem_readdata;
          rd_err_nxt  = 1'b0;
          done_nxt    = port_onehot(owner);
          state_nxt   = RESPOND;
        end else if (timer == TIMER_W'(TIMEOUT)) begin
          rd_data_nxt = '0;
          rd_err_nxt  = 1'b1;
          done_nxt    = port_onehot(owner);
          state_nxt   = RESPOND;
        end else begin
          // Leaves at TIMEOUT, so the counter cannot wrap.
          timer_nxt   = timer + TIMER_W'(1);
        end
      end

      RESPOND: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
